// File: rtl/bip_control.sv
// Control unit for a small accumulator processor: owns the program counter
// and decodes the 16-bit instruction into datapath selects and RAM strobes.
module bip_control #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned OPCODE_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [OPCODE_WIDTH+ADDR_WIDTH-1:0]   instruction,
  output logic [ADDR_WIDTH-1:0]                program_counter,
  output logic [ADDR_WIDTH-1:0]                data_address,
  output logic [1:0]                           SelA,
  output logic                                 SelB,
  output logic                                 WrAcc,
  output logic                                 Op,
  output logic                                 WrRam,
  output logic                                 RdRam
);

  localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  localparam logic [1:0] SEL_RAM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  logic [OPCODE_WIDTH-1:0] opcode;

  assign opcode       = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign data_address = instruction[ADDR_WIDTH-1:0];

  // PC advances every edge except while a HLT opcode is presented; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      program_counter <= '0;
    end else if (opcode != OP_HLT) begin
      program_counter <= program_counter + ADDR_WIDTH'(1);
    end
  end

  // Zero-latency decode; everything forced low while reset is held.
  always_comb begin
    SelA  = SEL_RAM;
    SelB  = 1'b0;
    WrAcc = 1'b0;
    Op    = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (rst) begin
      case (opcode)
        OP_STO: begin
          WrRam = 1'b1;
        end
        OP_LD: begin
          WrAcc = 1'b1;
          RdRam = 1'b1;
        end
        OP_LDI: begin
          SelA  = SEL_IMM;
          WrAcc = 1'b1;
        end
        OP_ADD: begin
          SelA  = SEL_ALU;
          WrAcc = 1'b1;
          RdRam = 1'b1;
        end
        OP_ADDI: begin
          SelA  = SEL_ALU;
          SelB  = 1'b1;
          WrAcc = 1'b1;
        end
        OP_SUB: begin
          SelA  = SEL_ALU;
          Op    = 1'b1;
          WrAcc = 1'b1;
          RdRam = 1'b1;
        end
        OP_SUBI: begin
          SelA  = SEL_ALU;
          SelB  = 1'b1;
          Op    = 1'b1;
          WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: decode vector table with a scoreboard
// queue, plus hand-written PC wrap and asynchronous reset sequences.
module tb_bip_control;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [10:0] program_counter;
  logic [10:0] data_address;
  logic [1:0]  SelA;
  logic        SelB;
  logic        WrAcc;
  logic        Op;
  logic        WrRam;
  logic        RdRam;

  bip_control dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .program_counter (program_counter),
    .data_address    (data_address),
    .SelA            (SelA),
    .SelB            (SelB),
    .WrAcc           (WrAcc),
    .Op              (Op),
    .WrRam           (WrRam),
    .RdRam           (RdRam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [6:0]  ctrl;   // {SelA, SelB, Op, WrAcc, WrRam, RdRam}
    logic        inc;
  } vec_t;

  typedef struct {
    logic [6:0]  ctrl;
    logic [10:0] daddr;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  int          total = 0;
  int          bad   = 0;
  logic [10:0] pc_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] instr, input logic [6:0] ctrl);
    exp_t e;
    instruction = instr;
    e.ctrl  = ctrl;
    e.daddr = instr[10:0];
    sb.push_back(e);
  endtask

  task automatic sample(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_ctrl"}, 32'({SelA, SelB, Op, WrAcc, WrRam, RdRam}), 32'(e.ctrl));
      check({name, "_daddr"}, 32'(data_address), 32'(e.daddr));
    end
  endtask

  task automatic step_check_pc(input string name);
    @(posedge clk);
    #1;
    check({name, "_pc"}, 32'(program_counter), 32'(pc_exp));
  endtask

  initial begin
    int n;
    //                    instr     SelA SelB Op WrAcc WrRam RdRam       inc
    tbl[0]  = '{16'h0807, {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1}; // STO 7
    tbl[1]  = '{16'h0807, {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1}; // STO 7
    tbl[2]  = '{16'h1000, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b1}; // LD 0
    tbl[3]  = '{16'h1800, {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1}; // LDI 0
    tbl[4]  = '{16'h0000, {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0}; // HLT
    tbl[5]  = '{16'h0000, {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0}; // HLT
    tbl[6]  = '{16'h0123, {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0}; // HLT 0x123
    tbl[7]  = '{16'h3800, {2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b1}; // SUBI
    tbl[8]  = '{16'h2003, {2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b1}; // ADD 3
    tbl[9]  = '{16'h2C05, {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1}; // ADDI 0x405
    tbl[10] = '{16'h3001, {2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, 1'b1}; // SUB 1
    tbl[11] = '{16'hFFFF, {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1}; // opcode 11111
    tbl[12] = '{16'h4000, {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1}; // opcode 01000
    tbl[13] = '{16'h1FFE, {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1}; // LDI 0x7FE

    // Reset held with a non-HLT instruction: decode must still be forced low.
    rst    = 1'b0;
    pc_exp = '0;
    drive(16'h2005, 7'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_pc", 32'(program_counter), 32'd0);
    sample("rst_hold");

    // Release with HLT: PC must stay at 0.
    @(negedge clk);
    rst = 1'b1;
    drive(16'h0000, 7'b0);
    #1;
    sample("release_hlt");
    step_check_pc("release_hlt");
    step_check_pc("release_hlt2");

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].instr, tbl[i].ctrl);
      #1;
      sample($sformatf("vec%0d", i));
      pc_exp = pc_exp + 11'(tbl[i].inc);
      step_check_pc($sformatf("vec%0d", i));
    end

    // Run the PC up to 2047 with a NOP, then one edge must wrap to 0.
    @(negedge clk);
    drive(16'hF8FF, 7'b0);
    #1;
    sample("wrap_nop");
    n = 2047 - int'(pc_exp);
    repeat (n) @(posedge clk);
    #1;
    pc_exp = 11'd2047;
    check("wrap_top_pc", 32'(program_counter), 32'(pc_exp));
    pc_exp = 11'd0;
    step_check_pc("wrap_zero");

    // Async reset between edges while an LD is presented.
    @(negedge clk);
    drive(16'h1003, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    #1;
    sample("pre_async_ld");
    pc_exp = 11'd1;
    step_check_pc("pre_async");
    pc_exp = 11'd2;
    step_check_pc("pre_async2");
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb.push_back('{ctrl: 7'b0, daddr: 11'h003});
    #1;
    check("async_rst_pc", 32'(program_counter), 32'd0);
    sample("async_rst");
    pc_exp = 11'd0;
    step_check_pc("async_rst_held");

    // First edge after release counts.
    @(negedge clk);
    rst = 1'b1;
    pc_exp = 11'd1;
    step_check_pc("post_release");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of a small accumulator-based processor core.
- Owns the program counter that addresses instruction memory.
- Decodes the 16-bit instruction (5-bit opcode, 11-bit operand) into datapath selects and data-memory strobes.
- Sits between instruction memory (drives its address, receives the fetched instruction) and the accumulator/ALU datapath plus data RAM.

Parameters:
- ADDR_WIDTH, 11, width of program_counter, data_address and the instruction operand field.
- OPCODE_WIDTH, 5, width of the opcode field; INSTR width = OPCODE_WIDTH + ADDR_WIDTH = 16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-low.
- instruction  input  16  current instruction; [15:11] opcode, [10:0] operand.
- program_counter  output  11  instruction-memory address (registered).
- data_address  output  11  data-RAM address / immediate = instruction[10:0].
- SelA  output  2  accumulator input mux: 00 = RAM data, 01 = sign-extended immediate, 10 = ALU result, 11 unused.
- SelB  output  1  ALU operand B: 0 = RAM data, 1 = immediate.
- WrAcc  output  1  accumulator write enable.
- Op  output  1  ALU operation: 0 = add, 1 = subtract.
- WrRam  output  1  data-RAM write strobe.
- RdRam  output  1  data-RAM read strobe.

Behaviour:
- PC register:
  - rst low forces program_counter = 0 immediately, independent of clk.
  - On each rising clk edge with rst high: PC <= PC + 1 unless the current opcode is HLT, in which case PC holds.
  - Increment is modulo 2^11: 2047 wraps to 0.
  - Halt is level-based: if the instruction input changes to a non-HLT opcode, incrementing resumes on the next edge.
- data_address is combinational: always equals instruction[10:0], including during reset.
- Decode is combinational from instruction[15:11]. Outputs listed as SelA, SelB, Op, WrAcc, WrRam, RdRam:
  - 00000 HLT: 00, 0, 0, 0, 0, 0; PC holds.
  - 00001 STO (RAM[op] <- Acc): 00, 0, 0, 0, 1, 0.
  - 00010 LD (Acc <- RAM[op]): 00, 0, 0, 1, 0, 1.
  - 00011 LDI (Acc <- imm): 01, 0, 0, 1, 0, 0.
  - 00100 ADD (Acc <- Acc + RAM[op]): 10, 0, 0, 1, 0, 1.
  - 00101 ADDI: 10, 1, 0, 1, 0, 0.
  - 00110 SUB: 10, 0, 1, 1, 0, 1.
  - 00111 SUBI: 10, 1, 1, 1, 0, 0.
  - 01000–11111: NOP; all outputs 0; PC increments.
- While rst is low, all decode outputs are forced to 0 (SelA = 00, strobes deasserted), regardless of instruction.
- Release of rst: PC begins counting on the first rising edge after rst goes high.
- Reset asserted mid-operation: PC returns to 0 asynchronously; strobes drop in the same delta.
- No pipeline: decode outputs change in the same cycle as instruction; latency from instruction to control outputs is 0 cycles.
- No X propagation: every opcode value yields defined outputs.

Test Plan:
- Hold rst = 0 with instruction = 0x0000 and clock running -> program_counter = 0; all strobes 0; SelA = 00. Release rst -> PC holds at 0 (HLT).
- rst = 1, instruction = 0x0807 (STO 7) -> WrRam = 1, RdRam = 0, WrAcc = 0, data_address = 7; PC increments by 1 per rising edge.
- instruction = 0x1000 (LD 0) -> SelA = 00, WrAcc = 1, RdRam = 1. Then 0x1800 (LDI 0) -> SelA = 01, WrAcc = 1, RdRam = 0. PC keeps incrementing.
- instruction = 0x0000 (HLT) for 3 edges -> PC constant. Then 0x3800 (SUBI) -> SelA = 10, SelB = 1, Op = 1, WrAcc = 1; PC resumes incrementing.
- Opcodes 00100/00110 (ADD/SUB) -> SelB = 0, RdRam = 1, Op = 0 for ADD and 1 for SUB. Opcode 11111 -> all outputs 0, PC increments.
- Run PC to 2047 with a NOP, clock one edge -> PC = 0. Assert rst between clock edges -> PC = 0 immediately, before the next edge.
